// File: rtl/mem_access_master.sv
// MEM-stage initiator: turns a single-cycle pipeline load/store into a valid/ready
// request to the data memory, freezing the pipeline until it completes.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects word-unaligned addresses.
module mem_access_master #(
    parameter int DATA_W      = 32,
    parameter int MEM_BASE    = 1024,
    parameter int MEM_BYTES   = 4096,
    parameter int MADDR_W     = 12,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic               cmd_w_en,
    input  logic               cmd_r_en,
    input  logic [31:0]        cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               freeze,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               err,
    output logic               m_valid,
    output logic               m_we,
    output logic [MADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0]  m_wdata,
    input  logic               m_ready,
    input  logic [DATA_W-1:0]  m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] BASE_C     = 32'(MEM_BASE);
    localparam logic [31:0] LAST_OFF_C = 32'(MEM_BYTES - 4);
    localparam logic [7:0]  TO_LAST_C  = 8'(TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_we_q, m_we_d;
    logic [MADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]    m_wdata_q, m_wdata_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 err_q, err_d;
    logic                 freeze_s;
    logic                 mem_cmd_s;
    logic [31:0]          off_s;
    logic                 in_range_s;
    logic                 misalign_s;

    assign mem_cmd_s  = cmd_valid & (cmd_w_en | cmd_r_en);
    assign off_s      = cmd_addr - BASE_C;
    assign in_range_s = (cmd_addr >= BASE_C) && (off_s <= LAST_OFF_C);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = (cmd_addr[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, request and response logic for the transaction FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_valid_d  = m_valid_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        rd_valid_d = 1'b0;
        rd_data_d  = {DATA_W{1'b0}};
        err_d      = 1'b0;
        freeze_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                freeze_s = mem_cmd_s;
                cnt_d    = 8'd0;
                if (mem_cmd_s) begin
                    if (in_range_s && !misalign_s) begin
                        m_valid_d = 1'b1;
                        m_we_d    = cmd_w_en;
                        m_addr_d  = off_s[MADDR_W-1:0];
                        m_wdata_d = cmd_wdata;
                        state_d   = ST_REQ;
                    end else begin
                        rd_valid_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                freeze_s = 1'b1;
                if (m_ready) begin
                    // Stores (including store+load commands) return no data
                    m_valid_d  = 1'b0;
                    rd_valid_d = 1'b1;
                    rd_data_d  = m_we_q ? {DATA_W{1'b0}} : m_rdata;
                    cnt_d      = 8'd0;
                    state_d    = ST_RESP;
                end else if (cnt_q >= TO_LAST_C) begin
                    m_valid_d  = 1'b0;
                    rd_valid_d = 1'b1;
                    err_d      = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                freeze_s = 1'b0;
                cnt_d    = 8'd0;
                state_d  = ST_IDLE;
            end
            default: begin
                m_valid_d = 1'b0;
                cnt_d     = 8'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            m_valid_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= {MADDR_W{1'b0}};
            m_wdata_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_valid_q  <= m_valid_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    // The IDLE-state freeze follows the command combinationally, so gate it with reset
    assign freeze   = freeze_s & ~rst;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;
    assign m_valid  = m_valid_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized self-checking bench for mem_access_master against a transaction-level model.
module tb_mem_access_master;

    localparam int BASE    = 1024;
    localparam int BYTES   = 4096;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_w_en, cmd_r_en;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        freeze, rd_valid, err;
    logic [31:0] rd_data;
    logic        m_valid, m_we;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_access_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_w_en  (cmd_w_en),
        .cmd_r_en  (cmd_r_en),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .freeze    (freeze),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .m_valid   (m_valid),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint off;
        bit     ok;
        off = longint'(a) - longint'(BASE);
        ok  = (off >= 0) && (off <= BYTES - 4);
`ifdef MEM_ALIGN_CHECK_EN
        if (a % 4 != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    // One pipeline command; responder raises m_ready after d wait cycles (d >= TIMEOUT never answers).
    task automatic run_cmd(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdv, input int d);
        bit          ok, exp_err, got_rv;
        int          exp_mv, fr, mv;
        logic [31:0] exp_rd, exp_addr;
        ok       = addr_ok(a);
        exp_err  = !ok || (d >= TIMEOUT);
        exp_mv   = !ok ? 0 : ((d >= TIMEOUT) ? TIMEOUT : d + 1);
        exp_rd   = (exp_err || w) ? 32'd0 : rdv;
        exp_addr = (a - 32'(BASE)) % 32'(BYTES);
        cmd_valid = 1'b1; cmd_w_en = w; cmd_r_en = r; cmd_addr = a; cmd_wdata = wd;
        fr = 0; mv = 0; got_rv = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_rv; cyc++) begin
            if (rd_valid) begin
                got_rv  = 1'b1;
                m_ready = 1'b0;
                #1;
                check("err", 32'(err), 32'(exp_err));
                check("rd_data", rd_data, exp_rd);
                check("freeze_resp", 32'(freeze), 32'd0);
                check("m_valid_resp", 32'(m_valid), 32'd0);
            end else begin
                check("err_low", 32'(err), 32'd0);
                if (m_valid) begin
                    check("m_addr", 32'(m_addr), exp_addr);
                    check("m_we", 32'(m_we), 32'(w));
                    check("m_wdata", m_wdata, wd);
                    m_ready = (mv == d);
                    m_rdata = m_ready ? rdv : $urandom;
                    mv++;
                end else begin
                    m_ready = 1'b0;
                end
                #1;
                if (freeze) fr++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; m_ready = 1'b0;
        check("rv_seen", 32'(got_rv), 32'd1);
        check("m_valid_cycles", 32'(mv), 32'(exp_mv));
        check("freeze_cycles", 32'(fr), 32'(exp_mv + 1));
        check("rv_pulse", 32'(rd_valid), 32'd0);
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_w_en  = 1'b0; cmd_r_en = 1'b0;
        if (!cmd_valid) {cmd_w_en, cmd_r_en} = 2'($urandom);
        cmd_addr = 32'd1024 + 32'($urandom_range(0, 100));
        m_ready  = 1'b0;
        #1;
        check("idle_freeze", 32'(freeze), 32'd0);
        check("idle_m_valid", 32'(m_valid), 32'd0);
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'(BASE + 4 * $urandom_range(0, BYTES / 4 - 1));
            1:       return 32'(BASE + $urandom_range(0, BYTES + 8));
            2:       return 32'($urandom_range(0, BASE - 1));
            3:       return 32'(BASE + BYTES - 8 + $urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          d;
        logic        w, r;
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_w_en = 1'b0; cmd_r_en = 1'b1; cmd_addr = 32'd1028;
        cmd_wdata = 32'd0; m_ready = 1'b0; m_rdata = 32'd0;
        #1;
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        cmd_valid = 1'b0;
        #11 rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(1'b1, 1'b0, 32'd1024, 32'd8192, 32'hDEAD_BEEF, 2);
        run_cmd(1'b0, 1'b1, 32'd1028, 32'd0, 32'hC000_0000, 0);
        run_cmd(1'b0, 1'b1, 32'd1000, 32'd0, 32'h1234_5678, 0);
        run_cmd(1'b0, 1'b1, 32'(1024 + 4093), 32'd0, 32'h1234_5678, 0);
        run_cmd(1'b0, 1'b1, 32'(1024 + 4092), 32'd0, 32'h0BAD_F00D, 1);
        run_cmd(1'b0, 1'b1, 32'd1040, 32'd0, 32'h5555_AAAA, 100);
        run_cmd(1'b0, 1'b1, 32'd1044, 32'd0, 32'h7777_0001, TIMEOUT - 1);
        run_cmd(1'b1, 1'b1, 32'd1048, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1);
        run_cmd(1'b0, 1'b1, 32'd1026, 32'd0, 32'h2222_3333, 0);
        idle_cycle();

        // Asynchronous reset on the second REQ cycle abandons the transaction
        cmd_valid = 1'b1; cmd_w_en = 1'b0; cmd_r_en = 1'b1; cmd_addr = 32'd1028; m_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_req1_m_valid", 32'(m_valid), 32'd1);
        @(posedge clk); #1;
        check("rst_req2_m_valid", 32'(m_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_freeze", 32'(freeze), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("postrst_rd_valid", 32'(rd_valid), 32'd0);
            check("postrst_m_valid", 32'(m_valid), 32'd0);
        end
        run_cmd(1'b1, 1'b0, 32'd1032, 32'h0000_CAFE, 32'h0, 1);

        for (int n = 0; n < 80; n++) begin
            a = rand_addr();
            {w, r} = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 9))
                0:       d = TIMEOUT + $urandom_range(0, 3);
                1:       d = TIMEOUT - 1;
                default: d = $urandom_range(0, 4);
            endcase
            run_cmd(w, r, a, $urandom, $urandom, d);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- MEM-stage initiator that drives the data-memory responder port (byte address, 32-bit write data, write/read enables, 32-bit read data).
- Converts a single-cycle pipeline memory command into a valid/ready transaction with variable responder latency.
- Freezes the pipeline while a transaction is outstanding and returns load data with a one-cycle valid pulse to write-back.
- Adds address rebasing, range checking and a ready timeout.

Parameters:
- DATA_W, 32, data width (fixed 4 bytes per access)
- MEM_BASE, 1024, CPU byte address that maps to memory offset 0
- MEM_BYTES, 4096, responder capacity in bytes; valid offsets 0..MEM_BYTES-4
- MADDR_W, 12, memory-side address width (log2 MEM_BYTES)
- TIMEOUT_CYC, 15, max cycles waiting for m_ready before abort (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  EX/MEM register holds a valid instruction
- cmd_w_en  in  1  store
- cmd_r_en  in  1  load
- cmd_addr  in  32  byte address (ALU result)
- cmd_wdata  in  32  store value (Rd contents)
- freeze  out  1  stall pipeline / hold EX/MEM register
- rd_valid  out  1  one-cycle pulse, load result/completion
- rd_data  out  32  load data (0 for stores or errors)
- err  out  1  one-cycle pulse with rd_valid on range/timeout/align error
- m_valid  out  1  request to responder
- m_we  out  1  write request (else read)
- m_addr  out  MADDR_W  rebased byte offset
- m_wdata  out  32  write data
- m_ready  in  1  responder accepts and completes the request this cycle
- m_rdata  in  32  read data, valid when m_valid and m_ready

Behaviour:
- Reset (async, immediate): state IDLE; m_valid, m_we, m_addr, m_wdata, rd_valid, rd_data, err, timeout counter = 0; freeze forced 0 while rst is high.
- Memory command: cmd_valid & (cmd_w_en | cmd_r_en). If both enables are set, treat as a store; no read data is returned.
- Non-memory commands: freeze=0 and no state change.
- States: IDLE, REQ, RESP.
- IDLE:
  - freeze = memory command (combinational).
  - At the clock edge, compute off = cmd_addr - MEM_BASE (32-bit, unsigned).
  - In range (cmd_addr >= MEM_BASE and off <= MEM_BYTES-4): register m_addr=off[MADDR_W-1:0], m_wdata, m_we; set m_valid=1; go to REQ.
  - Out of range: no memory request; go to RESP with error flag set.
- REQ:
  - freeze=1; m_valid, m_addr, m_we and m_wdata are held stable.
  - Counter increments each cycle.
  - m_ready=1: capture m_rdata when it is a read (else capture 0); drop m_valid; go to RESP.
  - Counter reaches TIMEOUT_CYC with m_ready still 0: drop m_valid; rd_data=0; error flag set; go to RESP.
- RESP (exactly 1 cycle):
  - freeze=0; rd_valid=1; err=error flag; rd_data as captured.
  - Next state IDLE; counter cleared.
  - The pipeline advances on the edge that ends RESP, so the same command is never reissued.
- Latency: responder ready in the first REQ cycle gives freeze high for 2 cycles (IDLE detect + REQ), then RESP. Each extra wait cycle adds 1.
- Back-to-back commands: a new command is first seen in IDLE on the cycle after RESP; one idle bubble per access is permitted.
- rd_valid and err are low in every state other than RESP.
- Reset mid-REQ: m_valid drops asynchronously; the transaction is abandoned and no rd_valid is produced.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: in IDLE, a memory command with cmd_addr[1:0] != 0 issues no request and goes directly to RESP with err=1 and rd_data=0.
- Undefined: the low address bits pass through unchanged and the responder sees unaligned offsets.

Test Plan:
- Store cmd_addr=1024, wdata=8192, m_ready high on the 3rd REQ cycle -> m_addr=0, m_we=1, m_wdata=8192 held stable for 3 cycles; freeze high 4 cycles; then rd_valid=1, err=0, rd_data=0.
- Load cmd_addr=1028, m_ready immediately, m_rdata=0xC0000000 -> m_addr=4, freeze high 2 cycles, rd_valid pulse with rd_data=0xC0000000.
- Load cmd_addr=1000 and cmd_addr=1024+4093 -> no m_valid; one freeze cycle; RESP with err=1 and rd_data=0.
- Load with m_ready held 0 -> m_valid high exactly TIMEOUT_CYC=15 cycles, then err=1, rd_data=0, FSM back to IDLE.
- Reset asserted on the 2nd REQ cycle -> m_valid, freeze and rd_valid go 0 immediately; after reset release, a new store to 1032 proceeds normally.
- With MEM_ALIGN_CHECK_EN, load cmd_addr=1026 -> no m_valid, err=1; without it -> m_addr=2 issued.
